// File: rtl/pid_pkg.sv
// pid_pkg: shared constants, types and helpers for the PID controller core.
//   CFG_KP/CFG_KI/CFG_KD : cfg_addr codes of the three gain registers
//   sat_e                : classification of the shift-and-saturate result
//   acc_w()              : signed accumulator width for a given data/gain width
package pid_pkg;

  localparam logic [1:0] CFG_KP = 2'd0;
  localparam logic [1:0] CFG_KI = 2'd1;
  localparam logic [1:0] CFG_KD = 2'd2;

  typedef enum logic [1:0] {
    SatNone,
    SatHi,
    SatLo
  } sat_e;

  // Room for a (WIDTH+2)-bit signed difference times an unsigned gain, plus
  // headroom for summing the P, I and D terms.
  function automatic int unsigned acc_w(int unsigned width, int unsigned coef_w);
    return width + coef_w + 4;
  endfunction

endpackage

// File: rtl/pid_sat.sv
// pid_sat: arithmetic shift right by FRAC, then clip to an unsigned WIDTH-bit word.
// Ports:
//   sum_i      signed ACC_W  fixed-point P+I+D sum
//   control_o  WIDTH         clipped control word
//   sat_hi_o   1             result was above 2^WIDTH-1 and was clipped
//   sat_lo_o   1             result was negative and was clipped to zero
module pid_sat
  import pid_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 20,
  parameter int unsigned FRAC  = 4
) (
  input  logic signed [ACC_W-1:0] sum_i,
  output logic        [WIDTH-1:0] control_o,
  output logic                    sat_hi_o,
  output logic                    sat_lo_o
);

  logic signed [ACC_W-1:0] shifted;
  sat_e                    sat_kind;

  assign shifted = sum_i >>> FRAC;

  always_comb begin
    sat_kind = SatNone;
    if (shifted[ACC_W-1]) begin
      sat_kind = SatLo;
    end else if (|shifted[ACC_W-2:WIDTH]) begin
      sat_kind = SatHi;
    end
  end

  always_comb begin
    control_o = shifted[WIDTH-1:0];
    sat_hi_o  = 1'b0;
    sat_lo_o  = 1'b0;
    unique case (sat_kind)
      SatHi: begin
        control_o = '1;
        sat_hi_o  = 1'b1;
      end
      SatLo: begin
        control_o = '0;
        sat_lo_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pid_ctrl_core.sv
// pid_ctrl_core: three-stage pipelined PID controller with runtime-loadable gains
// and a clamped integrator. One sample per cycle, result three cycles later.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   clr                  clear integrator, error history and in-flight samples
//   in_valid             setpoint/feedback sample strobe
//   setpoint, feedback   unsigned WIDTH-bit target and measurement
//   cfg_we/addr/data     gain write (0=Kp, 1=Ki, 2=Kd, 3=ignored)
//   out_valid            one-cycle pulse per surviving sample
//   control              saturated control word, held between pulses
//   sat_hi, sat_lo       last output was clipped high / low
//   int_clamped          last integrator update hit +/-INT_LIM
// Build option: define PID_ANTIWINDUP_EN to freeze the integrator while the last
// output is saturated in the direction the update would push it.
module pid_ctrl_core
  import pid_pkg::*;
#(
  parameter int unsigned       WIDTH   = 8,
  parameter int unsigned       COEF_W  = 8,
  parameter int unsigned       FRAC    = 4,
  parameter logic [COEF_W-1:0] KP_INIT = 8'h10,
  parameter logic [COEF_W-1:0] KI_INIT = 8'h02,
  parameter logic [COEF_W-1:0] KD_INIT = 8'h01,
  parameter int unsigned       INT_LIM = 2 ** (WIDTH + FRAC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  setpoint,
  input  logic [WIDTH-1:0]  feedback,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [COEF_W-1:0] cfg_data,
  output logic              out_valid,
  output logic [WIDTH-1:0]  control,
  output logic              sat_hi,
  output logic              sat_lo,
  output logic              int_clamped
);

  localparam int unsigned AccW = acc_w(WIDTH, COEF_W);
  localparam int unsigned ErrW = WIDTH + 1;
  localparam int unsigned DifW = WIDTH + 2;
  localparam logic signed [AccW-1:0] IntLimPos = AccW'(INT_LIM);
  localparam logic signed [AccW-1:0] IntLimNeg = -IntLimPos;

  // Gains
  logic [COEF_W-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  // Stage 1
  logic                   s1_valid_q, s1_valid_d, have_prev_q, have_prev_d;
  logic signed [ErrW-1:0] err_q, err_d, prev_err_q, prev_err_d;
  logic signed [DifW-1:0] derr_q, derr_d;
  // Stage 2
  logic                   s2_valid_q, s2_valid_d;
  logic signed [AccW-1:0] p_q, p_d, d_q, d_d, integ_q, integ_d;
  logic                   int_clamped_q, int_clamped_d;
  // Stage 3
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       control_q, control_d;
  logic                   sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;

  // Datapath
  logic signed [ErrW-1:0] err_in;
  logic signed [DifW-1:0] derr_in;
  logic signed [AccW-1:0] err_ext, derr_ext, kp_ext, ki_ext, kd_ext;
  logic signed [AccW-1:0] ki_term, int_sum, sum3;
  logic [WIDTH-1:0]       sat_control;
  logic                   sat_hi_next, sat_lo_next;
  logic                   hold_int;

  assign err_in  = $signed({1'b0, setpoint}) - $signed({1'b0, feedback});
  assign derr_in = $signed({err_in[ErrW-1], err_in})
                 - $signed({prev_err_q[ErrW-1], prev_err_q});

  assign err_ext  = {{(AccW-ErrW){err_q[ErrW-1]}}, err_q};
  assign derr_ext = {{(AccW-DifW){derr_q[DifW-1]}}, derr_q};
  assign kp_ext   = {{(AccW-COEF_W){1'b0}}, kp_q};
  assign ki_ext   = {{(AccW-COEF_W){1'b0}}, ki_q};
  assign kd_ext   = {{(AccW-COEF_W){1'b0}}, kd_q};

  assign ki_term = ki_ext * err_ext;
  assign int_sum = integ_q + ki_term;
  assign sum3    = p_q + integ_q + d_q;

`ifdef PID_ANTIWINDUP_EN
  logic ki_term_pos, ki_term_neg;
  assign ki_term_neg = ki_term[AccW-1];
  assign ki_term_pos = !ki_term[AccW-1] && (ki_term != '0);
  // Flags are those of the most recent out_valid, i.e. the registered outputs.
  assign hold_int = (sat_hi_q && ki_term_pos) || (sat_lo_q && ki_term_neg);
`else
  assign hold_int = 1'b0;
`endif

  pid_sat #(
    .WIDTH(WIDTH),
    .ACC_W(AccW),
    .FRAC (FRAC)
  ) u_sat (
    .sum_i    (sum3),
    .control_o(sat_control),
    .sat_hi_o (sat_hi_next),
    .sat_lo_o (sat_lo_next)
  );

  always_comb begin
    kp_d          = kp_q;
    ki_d          = ki_q;
    kd_d          = kd_q;
    s1_valid_d    = in_valid;
    have_prev_d   = have_prev_q;
    err_d         = err_q;
    derr_d        = derr_q;
    prev_err_d    = prev_err_q;
    s2_valid_d    = s1_valid_q;
    p_d           = p_q;
    d_d           = d_q;
    integ_d       = integ_q;
    int_clamped_d = int_clamped_q;
    out_valid_d   = s2_valid_q;
    control_d     = control_q;
    sat_hi_d      = sat_hi_q;
    sat_lo_d      = sat_lo_q;

    if (cfg_we) begin
      case (cfg_addr)
        CFG_KP:  kp_d = cfg_data;
        CFG_KI:  ki_d = cfg_data;
        CFG_KD:  kd_d = cfg_data;
        default: ;
      endcase
    end

    if (in_valid) begin
      err_d       = err_in;
      derr_d      = have_prev_q ? derr_in : '0;
      prev_err_d  = err_in;
      have_prev_d = 1'b1;
    end

    if (s1_valid_q) begin
      p_d           = kp_ext * err_ext;
      d_d           = kd_ext * derr_ext;
      int_clamped_d = 1'b0;
      if (!hold_int) begin
        if (int_sum > IntLimPos) begin
          integ_d       = IntLimPos;
          int_clamped_d = 1'b1;
        end else if (int_sum < IntLimNeg) begin
          integ_d       = IntLimNeg;
          int_clamped_d = 1'b1;
        end else begin
          integ_d = int_sum;
        end
      end
    end

    if (s2_valid_q) begin
      control_d = sat_control;
      sat_hi_d  = sat_hi_next;
      sat_lo_d  = sat_lo_next;
    end

    // clr drops everything in flight (including a coincident sample) but keeps
    // gains and the last visible output state.
    if (clr) begin
      s1_valid_d    = 1'b0;
      s2_valid_d    = 1'b0;
      out_valid_d   = 1'b0;
      have_prev_d   = 1'b0;
      prev_err_d    = '0;
      integ_d       = '0;
      int_clamped_d = int_clamped_q;
      control_d     = control_q;
      sat_hi_d      = sat_hi_q;
      sat_lo_d      = sat_lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kp_q          <= KP_INIT;
      ki_q          <= KI_INIT;
      kd_q          <= KD_INIT;
      s1_valid_q    <= 1'b0;
      have_prev_q   <= 1'b0;
      err_q         <= '0;
      derr_q        <= '0;
      prev_err_q    <= '0;
      s2_valid_q    <= 1'b0;
      p_q           <= '0;
      d_q           <= '0;
      integ_q       <= '0;
      int_clamped_q <= 1'b0;
      out_valid_q   <= 1'b0;
      control_q     <= '0;
      sat_hi_q      <= 1'b0;
      sat_lo_q      <= 1'b0;
    end else begin
      kp_q          <= kp_d;
      ki_q          <= ki_d;
      kd_q          <= kd_d;
      s1_valid_q    <= s1_valid_d;
      have_prev_q   <= have_prev_d;
      err_q         <= err_d;
      derr_q        <= derr_d;
      prev_err_q    <= prev_err_d;
      s2_valid_q    <= s2_valid_d;
      p_q           <= p_d;
      d_q           <= d_d;
      integ_q       <= integ_d;
      int_clamped_q <= int_clamped_d;
      out_valid_q   <= out_valid_d;
      control_q     <= control_d;
      sat_hi_q      <= sat_hi_d;
      sat_lo_q      <= sat_lo_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign control     = control_q;
  assign sat_hi      = sat_hi_q;
  assign sat_lo      = sat_lo_q;
  assign int_clamped = int_clamped_q;

endmodule

// File: tb/tb_pid_ctrl_core.sv
// Scoreboard bench for pid_ctrl_core (default build, anti-windup disabled).
// A plain-integer PID model computes each sample's result at issue time; a
// monitor pops and compares whenever out_valid is seen.
module tb_pid_ctrl_core;

  localparam int Frac   = 4;
  localparam int IntLim = 4096;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, cfg_we;
  logic [7:0] setpoint, feedback, cfg_data;
  logic [1:0] cfg_addr;
  logic       out_valid, sat_hi, sat_lo, int_clamped;
  logic [7:0] control;

  always #5 clk = ~clk;

  pid_ctrl_core dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .setpoint   (setpoint),
    .feedback   (feedback),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .out_valid  (out_valid),
    .control    (control),
    .sat_hi     (sat_hi),
    .sat_lo     (sat_lo),
    .int_clamped(int_clamped)
  );

  typedef struct {
    int tag;
    int ctrl;
    bit hi;
    bit lo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  // Model state
  int m_kp, m_ki, m_kd, m_int, m_prev;
  bit m_have_prev, m_clamp;

  // Directed-test override of the pushed expectation
  bit ovr_valid = 0;
  int ovr_ctrl;
  bit ovr_hi, ovr_lo;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Samples issued in this cycle or the two before are still in flight.
  task automatic prune();
    while (sb.size() > 0 && sb[$].tag >= cyc - 2) void'(sb.pop_back());
  endtask

  task automatic model_clear();
    m_int = 0;
    m_prev = 0;
    m_have_prev = 0;
    prune();
  endtask

  task automatic model_reset();
    m_kp = 16;
    m_ki = 2;
    m_kd = 1;
    m_clamp = 0;
    model_clear();
  endtask

  task automatic model_sample(input int sp, input int fb, output exp_t x);
    int e, de, total, s;
    e = sp - fb;
    de = m_have_prev ? e - m_prev : 0;
    m_prev = e;
    m_have_prev = 1;
    m_int = m_int + m_ki * e;
    m_clamp = 0;
    if (m_int > IntLim) begin
      m_int = IntLim;
      m_clamp = 1;
    end else if (m_int < -IntLim) begin
      m_int = -IntLim;
      m_clamp = 1;
    end
    total = m_kp * e + m_int + m_kd * de;
    s = total >>> Frac;
    x.hi = 0;
    x.lo = 0;
    if (s < 0) begin
      x.ctrl = 0;
      x.lo = 1;
    end else if (s > 255) begin
      x.ctrl = 255;
      x.hi = 1;
    end else begin
      x.ctrl = s;
    end
  endtask

  task automatic cycle_in(bit r, bit c, bit iv, int sp, int fb, bit we, int addr, int data);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r;
    clr = c;
    in_valid = iv;
    setpoint = sp[7:0];
    feedback = fb[7:0];
    cfg_we = we;
    cfg_addr = addr[1:0];
    cfg_data = data[7:0];
    if (r) begin
      model_reset();
    end else begin
      if (we) begin
        case (addr)
          0: m_kp = data;
          1: m_ki = data;
          2: m_kd = data;
          default: ;
        endcase
      end
      if (c) begin
        model_clear();
      end else if (iv) begin
        model_sample(sp, fb, x);
        if (ovr_valid) begin
          x.ctrl = ovr_ctrl;
          x.hi = ovr_hi;
          x.lo = ovr_lo;
          ovr_valid = 0;
        end
        x.tag = cyc;
        sb.push_back(x);
      end
    end
  endtask

  task automatic idle();
    cycle_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg(int addr, int data);
    cycle_in(0, 0, 0, 0, 0, 1, addr, data);
  endtask

  task automatic clr_cycle();
    cycle_in(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic send(int sp, int fb);
    cycle_in(0, 0, 1, sp, fb, 0, 0, 0);
  endtask

  task automatic send_exp(int sp, int fb, int c, bit hi, bit lo);
    ovr_valid = 1;
    ovr_ctrl = c;
    ovr_hi = hi;
    ovr_lo = lo;
    send(sp, fb);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      idle();
      n++;
    end
    check("drain pending outputs", sb.size(), 0);
    sb.delete();
    repeat (3) idle();
  endtask

  // Monitor
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious out_valid", 1, 0);
      end else begin
        mon_x = sb.pop_front();
        check("control", int'(control), mon_x.ctrl);
        check("sat_hi", int'(sat_hi), int'(mon_x.hi));
        check("sat_lo", int'(sat_lo), int'(mon_x.lo));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    clr = 0;
    in_valid = 0;
    setpoint = 0;
    feedback = 0;
    cfg_we = 0;
    cfg_addr = 0;
    cfg_data = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", int'(out_valid), 0);
    check("reset control", int'(control), 0);
    check("reset sat_hi", int'(sat_hi), 0);
    check("reset sat_lo", int'(sat_lo), 0);
    check("reset int_clamped", int'(int_clamped), 0);
    idle();

    // Proportional path
    cfg(1, 0);
    cfg(2, 0);
    send_exp(120, 100, 20, 0, 0);
    drain();

    // Integrator, back-to-back
    cfg(0, 0);
    cfg(1, 16);
    clr_cycle();
    for (int k = 1; k <= 4; k++) send_exp(105, 100, 5 * k, 0, 0);
    drain();

    // Positive clip with default gains
    cycle_in(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    send_exp(255, 0, 255, 1, 0);
    drain();

    // Negative error
    clr_cycle();
    send_exp(0, 200, 0, 0, 1);
    drain();

    // Derivative
    cfg(0, 0);
    cfg(1, 0);
    cfg(2, 16);
    clr_cycle();
    send_exp(10, 0, 0, 0, 0);
    send_exp(30, 0, 20, 0, 0);
    drain();

    // clr one cycle after a sample drops it and clears the integrator
    cfg(2, 0);
    cfg(1, 16);
    clr_cycle();
    send(105, 100);
    clr_cycle();
    repeat (4) idle();
    send_exp(105, 100, 5, 0, 0);
    drain();

    // Integrator clamp flag
    cfg(1, 255);
    clr_cycle();
    send_exp(255, 0, 255, 1, 0);
    drain();
    check("int_clamped after large step", int'(int_clamped), int'(m_clamp));
    cfg(1, 1);
    send_exp(0, 10, 255, 0, 0);
    drain();
    check("int_clamped after small step", int'(int_clamped), int'(m_clamp));

    // Randomised traffic including gain writes, clr and rst mid-pipeline
    cycle_in(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 800; i++) begin
      bit r, c, iv, we;
      int a, d;
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 39) == 0);
      iv = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 9) == 0);
      a = $urandom_range(0, 3);
      d = $urandom_range(0, 255) >> $urandom_range(0, 4);
      cycle_in(r, c, iv, $urandom_range(0, 255), $urandom_range(0, 255), we, a, d);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pid_ctrl_core.md
# pid_ctrl_core

Parametrised, pipelined PID controller core, successor to the fixed 8-bit controller in the top-level wrapper. It accepts a setpoint/feedback sample pair under a valid strobe and returns a saturated, unsigned control word three cycles later. Gains are runtime-loadable and the integrator is clamped. The core sits between the input pins (sample source) and the output driver / PWM stage.

## Interface
- WIDTH, 8: setpoint, feedback and control width (unsigned).
- COEF_W, 8: gain register width (unsigned, fixed-point with FRAC fraction bits).
- FRAC, 4: fraction bits of the gains; the final sum is arithmetically shifted right by FRAC.
- KP_INIT, 8'h10: reset value of Kp (1.0 at FRAC=4).
- KI_INIT, 8'h02: reset value of Ki.
- KD_INIT, 8'h01: reset value of Kd.
- INT_LIM, 2**(WIDTH+FRAC): integrator magnitude limit; must be a positive value.

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous controller clear: integrator, history and pipeline; gains are kept.
- in_valid  in  1  sample strobe.
- setpoint  in  WIDTH  target value.
- feedback  in  WIDTH  measured value.
- cfg_we  in  1  gain write strobe.
- cfg_addr  in  2  gain select: 0=Kp, 1=Ki, 2=Kd, 3=ignored.
- cfg_data  in  COEF_W  gain value.
- out_valid  out  1  control word valid, one-cycle pulse per sample.
- control  out  WIDTH  saturated control word; holds its value between pulses.
- sat_hi / sat_lo  out  1 each  last output was clipped high / low.
- int_clamped  out  1  last integrator update hit ±INT_LIM.

## Operation
- ACC_W = WIDTH + COEF_W + 4, signed. Error e = setpoint − feedback, computed at WIDTH+1 bits, signed.
- Stage 1 (on in_valid): register e and de = e − prev_e. prev_e ← e. For the first sample after rst or clr, de = 0.
- Stage 2: P = Kp·e and D = Kd·de. The integrator update is I ← clamp(I + Ki·e, −INT_LIM, +INT_LIM). int_clamped is set when the limit is applied.
- Stage 3: S = (P + I + D) >>> FRAC. control = 0 if S < 0 (sat_lo=1); 2^WIDTH−1 if S exceeds the maximum (sat_hi=1); otherwise S. Assert out_valid.
- Throughput is one sample per cycle. There is no backpressure.
- Gain write: takes effect for the sample in stage 2 on the cycle after cfg_we. cfg_addr=3 has no effect.
- clr: zeroes I, prev_e and the first-sample flag, and drops all in-flight samples (no out_valid for them). control and the sat flags hold their values.
- clr together with in_valid: clr wins and the sample is dropped.
- rst: clears everything clr clears. Gains go to their *_INIT values. control=0, out_valid=0, sat_hi=0, sat_lo=0, int_clamped=0.
- rst in mid-pipeline: no out_valid is produced for any sample in flight.

## Timing
- Latency: in_valid at cycle N produces out_valid at N+3.
- All outputs are registered. No combinational path from input to output.
- Integrator state seen by sample k+1 includes sample k's contribution, including back-to-back samples.

## Configuration
- PID_ANTIWINDUP_EN defined: the stage-2 integrator update is skipped when sat_hi=1 and Ki·e>0, or when sat_lo=1 and Ki·e<0. The flags are those of the most recent out_valid. The ±INT_LIM clamp still applies.
- Undefined: only the ±INT_LIM clamp limits the integrator.

## Structure
- pid_pkg holds:
  - cfg address constants CFG_KP, CFG_KI, CFG_KD;
  - an acc_w(WIDTH, COEF_W) function;
  - the saturation-flag enum/struct.
- Sub-module pid_sat: the shift-and-saturate stage (signed ACC_W in; WIDTH out plus sat_hi/sat_lo). It is instantiated in stage 3.

## Test plan
- Proportional path: Ki=0, Kd=0 by cfg; setpoint=120, feedback=100 → control=20 at N+3, no sat flags.
- Integrator: Kp=0, Kd=0, Ki=16; four back-to-back samples with e=5 → controls 5, 10, 15, 20.
- Positive clip: default gains; setpoint=255, feedback=0 → S=286 → control=255, sat_hi=1.
- Negative error: setpoint=0, feedback=200 → control=0, sat_lo=1.
- Derivative: Kp=0, Ki=0, Kd=16; e=10 then e=30 → controls 0, 20.
- clr asserted at N+1 after in_valid at N → no out_valid. A following e=5 sample with Kp=0, Kd=0, Ki=16 → control=5, confirming I was cleared.
